// File: rtl/wave_counter.sv
// Modulo up/down counter addressing a one-period waveform table.
// The count wraps in both directions, so playback never stalls at an end of the table.
module wave_counter #(
    parameter int max_val_p = 15,
    parameter int width_p   = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               wrap_o
);

    if (max_val_p < 1) begin : g_bad_max
        $error("wave_counter: max_val_p must be >= 1");
    end
    if (width_p < $clog2(max_val_p + 1)) begin : g_bad_width
        $error("wave_counter: width_p too small to hold max_val_p");
    end

    localparam logic [width_p-1:0] max_c = width_p'(max_val_p);
    localparam logic [width_p-1:0] one_c = width_p'(1);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;
    logic               step_up;
    logic               step_down;

    assign step_up   = up_i & ~down_i;
    assign step_down = down_i & ~up_i;

    always_comb begin
        // NOTE: default first, so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (step_up) begin
            // >= rather than == so a corrupted out-of-range count recovers to 0.
            count_d = (count_q >= max_c) ? '0 : count_q + one_c;
        end else if (step_down) begin
            count_d = (count_q == '0) ? max_c : count_q - one_c;
        end
    end

    // NOTE: non-blocking assignment for state so all flops update together on the edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = reset_i & ((step_up & (count_q == max_c)) |
                                (step_down & (count_q == '0)));

endmodule

// File: tb/tb_wave_counter.sv
// Scoreboard bench for wave_counter: three instances (max 99, 4, 7) driven from
// directed vectors, checked once per cycle on the falling edge by a separate monitor.
module tb_wave_counter;

    typedef struct {
        int    count;
        bit    wrap;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst99 = 1'b0, up99 = 1'b0, dn99 = 1'b0;
    logic       rst4  = 1'b0, up4  = 1'b0, dn4  = 1'b0;
    logic       rst7  = 1'b0, up7  = 1'b0, dn7  = 1'b0;
    logic [6:0] c99;
    logic [2:0] c4, c7;
    logic       w99, w4, w7;

    wave_counter #(.max_val_p(99)) u99 (
        .clk_i(clk), .reset_i(rst99), .up_i(up99), .down_i(dn99), .count_o(c99), .wrap_o(w99));
    wave_counter #(.max_val_p(4)) u4 (
        .clk_i(clk), .reset_i(rst4), .up_i(up4), .down_i(dn4), .count_o(c4), .wrap_o(w4));
    wave_counter #(.max_val_p(7)) u7 (
        .clk_i(clk), .reset_i(rst7), .up_i(up7), .down_i(dn7), .count_o(c7), .wrap_o(w7));

    exp_t q99[$];
    exp_t q4[$];
    exp_t q7[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected sample per DUT per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q99.size() > 0) begin
            e = q99.pop_front();
            check({e.tag, "/count99"}, {25'd0, c99}, e.count);
            check({e.tag, "/wrap99"}, {31'd0, w99}, {31'd0, e.wrap});
        end
        if (q4.size() > 0) begin
            e = q4.pop_front();
            check({e.tag, "/count4"}, {29'd0, c4}, e.count);
            check({e.tag, "/wrap4"}, {31'd0, w4}, {31'd0, e.wrap});
        end
        if (q7.size() > 0) begin
            e = q7.pop_front();
            check({e.tag, "/count7"}, {29'd0, c7}, e.count);
            check({e.tag, "/wrap7"}, {31'd0, w7}, {31'd0, e.wrap});
        end
    end

    task automatic drive99(input bit rst, input bit up, input bit dn,
                           input int ec, input bit ew, input string tag);
        @(posedge clk);
        #1;
        rst99 = rst; up99 = up; dn99 = dn;
        q99.push_back('{count: ec, wrap: ew, tag: tag});
    endtask

    task automatic drive4(input bit rst, input bit up, input bit dn,
                          input int ec, input bit ew, input string tag);
        @(posedge clk);
        #1;
        rst4 = rst; up4 = up; dn4 = dn;
        q4.push_back('{count: ec, wrap: ew, tag: tag});
    endtask

    task automatic drive7(input bit rst, input bit up, input bit dn,
                          input int ec, input bit ew, input string tag);
        @(posedge clk);
        #1;
        rst7 = rst; up7 = up; dn7 = dn;
        q7.push_back('{count: ec, wrap: ew, tag: tag});
    endtask

    task automatic seq99();
        drive99(0, 0, 0, 0, 0, "rst99");
        drive99(0, 1, 0, 0, 0, "rst99_up");
        // 105 up steps: 0..99, 0..4 shown before each step, then 5 on the idle cycle.
        for (int i = 0; i <= 105; i++) begin
            bit up;
            up = (i < 105);
            drive99(1, up, 0, i % 100, up && ((i % 100) == 99), "up_wrap");
        end
        drive99(1, 1, 0, 5, 0, "to7");
        drive99(1, 1, 0, 6, 0, "to7");
        drive99(1, 0, 0, 7, 0, "hold");
        drive99(1, 1, 1, 7, 0, "cancel");
        drive99(1, 0, 0, 7, 0, "after_cancel");
        for (int c = 7; c <= 36; c++) drive99(1, 1, 0, c, 0, "to37");
        drive99(1, 0, 0, 37, 0, "at37");
        // Reset dropped 1 ns after the edge; count must be 0 well before the next edge.
        drive99(0, 1, 0, 0, 0, "rst_mid");
        drive99(0, 0, 1, 0, 0, "rst_down");
        drive99(0, 1, 0, 0, 0, "rst_up");
        drive99(1, 0, 0, 0, 0, "rst_release");
        drive99(1, 1, 0, 0, 0, "resume");
        drive99(1, 0, 0, 1, 0, "resume");
    endtask

    task automatic seq4();
        int dn_c[6]  = '{0, 4, 3, 2, 1, 0};
        bit dn_w[6]  = '{1, 0, 0, 0, 0, 1};
        bit mx_up[7] = '{1, 1, 0, 1, 1, 1, 1};
        int mx_c[7]  = '{0, 1, 2, 1, 2, 3, 4};
        bit mx_w[7]  = '{0, 0, 0, 0, 0, 0, 1};
        drive4(0, 0, 0, 0, 0, "rst4");
        drive4(0, 0, 1, 0, 0, "rst4_down");
        for (int i = 0; i < 6; i++) drive4(1, 1'b0, 1'b1, dn_c[i], dn_w[i], "down_wrap");
        drive4(1, 0, 0, 4, 0, "down_end");
        drive4(1, 1, 0, 4, 1, "up_from4");
        for (int i = 0; i < 7; i++) drive4(1, mx_up[i], !mx_up[i], mx_c[i], mx_w[i], "mixed");
        drive4(1, 0, 0, 0, 0, "mixed_end");
    endtask

    task automatic seq7();
        drive7(0, 0, 0, 0, 0, "rst7");
        drive7(0, 1, 0, 0, 0, "rst7_up");
        for (int i = 0; i < 9; i++) drive7(1, 1, 0, i % 8, i == 7, "pow2");
        drive7(1, 0, 0, 1, 0, "pow2_end");
    endtask

    initial begin
        int w99_bits, w7_bits;
        w99_bits = $bits(c99);
        w7_bits  = $bits(u7.count_o);
        check("width99", $bits(u99.count_o), w99_bits);
        check("width7", w7_bits, 3);

        fork
            seq99();
            seq4();
            seq7();
        join

        begin
            int budget = 10;
            while ((q99.size() + q4.size() + q7.size()) > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            check("drain", q99.size() + q4.size() + q7.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wave_counter.md
Name: wave_counter

Overview:
- Parameterised modulo up/down counter producing a wrapping address into a one-period waveform lookup table (e.g. a sinusoid ROM of depth max_val_p+1).
- Sits between the sample-request handshake (ready) and the waveform memory read port.
- Advances one step per enabled clock and wraps in both directions, so waveform playback is continuous.

Parameters:
- max_val_p, default 15: largest count value; the counter cycles over 0..max_val_p. Must be >= 1.
- width_p, default $clog2(max_val_p+1), minimum 1: width of count_o. With max_val_p=99, width_p is 7. Overriding it with a value smaller than $clog2(max_val_p+1) is illegal (elaboration error).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset. Counter clears immediately when low and is held while low.
- up_i  input  1  increment request for this cycle.
- down_i  input  1  decrement request for this cycle.
- count_o  output  width_p  current count, driven directly from the state register.
- wrap_o  output  1  combinational flag: the step taken at the next rising edge wraps the count.

Behaviour:
- Reset
  - reset_i low forces count to 0 asynchronously, with no clock required.
  - While reset_i is low, count_o=0 and wrap_o=0.
  - Deassertion is synchronised by the integrator. First possible update is the first rising edge with reset_i high.
- Update rule, per rising edge with reset_i high:
  - up_i=1, down_i=0: count <= (count==max_val_p) ? 0 : count+1.
  - up_i=0, down_i=1: count <= (count==0) ? max_val_p : count-1.
  - up_i=down_i (both 0 or both 1): count holds. Simultaneous up and down cancel; this is not an error.
- Latency: count_o reflects a request one cycle after the edge that samples it. There is no combinational path from up_i/down_i to count_o.
- wrap_o = reset_i & ((up_i & ~down_i & count==max_val_p) | (down_i & ~up_i & count==0)).
- Range
  - count never leaves 0..max_val_p. Values max_val_p+1 .. 2^width_p-1 are unreachable.
  - If corrupted into that range, the next up step goes to 0 and the next down step goes to count-1.
- Arithmetic
  - count is unsigned width_p bits.
  - Comparisons against max_val_p use width_p-bit constants; there is no reliance on natural overflow, since max_val_p+1 need not be a power of 2.
- max_val_p = 2^width_p - 1 is a legal case: wrap still occurs at max_val_p.
- Reset mid-operation: asserting reset_i at any time, including between edges or while up_i is high, clears count to 0 immediately. The count resumes from 0.
- No X propagation: with reset_i high, X on up_i/down_i is a bench error. The design must nonetheless not produce an out-of-range count from defined inputs.

Test Plan:
- Reset: max_val_p=99, drive reset_i=0 mid-cycle after counting to 37 -> count_o=0 before the next edge; stays 0 while reset_i=0 regardless of up_i.
- Up wrap: max_val_p=99, reset released, up_i=1 for 105 cycles -> count_o goes 1..99, then 0, 1..5. wrap_o=1 exactly in the cycle count_o=99.
- Down wrap: max_val_p=4, from 0 apply down_i=1 for 6 cycles -> count_o 4,3,2,1,0,4. wrap_o=1 in the first cycle (count 0) and when count returns to 0.
- Hold/cancel: at count 7 (max_val_p=99), cycles with up_i=down_i=0 then up_i=down_i=1 -> count_o remains 7, wrap_o=0.
- Mixed direction: max_val_p=4, sequence up,up,down,up,up,up,up (from 0) -> 1,2,1,2,3,4,0.
- Power-of-two edge: max_val_p=7 (width 3), up_i=1 for 9 cycles -> 1..7,0,1. Check count_o width is 3 and with max_val_p=99 width is 7.
